param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//   Parametrised up/down counter, the successor to the fixed 4-bit sync up counter.
//   Adds: programmable width and terminal value, direction control, sync clear and load,
//   wrap or saturate mode, an enable prescaler, and a terminal-count pulse.
//   Used as the general timer/event counter in datapath and control blocks.
// PARAMETERS
//   WIDTH     4    count width in bits, >= 2
//   MAX_COUNT 15   terminal value, 1 .. 2**WIDTH-1; count range is 0..MAX_COUNT
//   SATURATE  0    0 = wrap at the range ends, 1 = hold at the range ends
//   PRESCALE  1    enabled cycles per count step, 1 .. 256 (1 = step on every enabled cycle)
// PORTS
//   clock       in   1      rising-edge clock
//   reset       in   1      asynchronous reset, active-low (0 = reset)
//   clear       in   1      synchronous clear to 0
//   load        in   1      synchronous load of load_value
//   load_value  in   WIDTH  load data
//   enable      in   1      count enable, fed to the prescaler
//   up_down     in   1      1 = count up, 0 = count down
//   count       out  WIDTH  current count (registered)
//   tc          out  1      terminal-count pulse (registered)
// BEHAVIOUR
//   - Reset (reset=0, asynchronous): count=0, tc=0, prescaler=0. Takes effect immediately.
//     Release is synchronous to clock; the first step can occur on the first edge after release.
//   - Priority on each rising edge: clear > load > step > hold.
//   - clear: count=0, prescaler=0, tc=0.
//   - load: count=min(load_value, MAX_COUNT) (clamped), prescaler=0, tc=0.
//   - Prescaler: counts cycles with enable=1. A step occurs on the enabled cycle where
//     prescaler==PRESCALE-1; the prescaler then returns to 0. With enable=0, the
//     prescaler holds its value.
//   - Step up: if count<MAX_COUNT, count+1.
//     At MAX_COUNT: count=0 (SATURATE=0) or hold MAX_COUNT (SATURATE=1).
//   - Step down: if count>0, count-1.
//     At 0: count=MAX_COUNT (SATURATE=0) or hold 0 (SATURATE=1).
//   - tc: 1 for exactly one cycle, registered on the same edge as a step taken at the range end:
//       up at MAX_COUNT, or down at 0, in either mode.
//     In saturate mode, tc repeats on every step attempted while held at the end.
//     tc=0 on all other cycles.
//   - Changing up_down takes effect on the next step. No glitch, no extra step.
//   - Arithmetic is WIDTH bits with no carry out. Values above MAX_COUNT are unreachable
//     except through reset, and reset only produces 0.
//   - Reset asserted mid-count aborts immediately. Nothing is retained.
// STRUCTURE
//   - counter_pkg: DIR_UP=1'b1, DIR_DOWN=1'b0, mode constants MODE_WRAP=0 and MODE_SAT=1.
//     Shared with the other counter/timer blocks.
//   - One sub-module, count_prescaler (param PRESCALE; ports clock, reset, clear, enable, tick).
//     The clear input is driven by clear|load. For PRESCALE=1, tick=enable combinationally.
//   - Top level: count register, next-state mux, end detect, tc register.
// TESTING
//   1. Reset with defaults: assert reset=0 mid-count at count=9.
//      -> count=0 and tc=0 with no clock edge needed. Release, enable=1, up -> 1,2,3 on successive edges.
//   2. Up wrap (defaults): load 14, enable=1, up -> 15, 0, 1; tc=1 only on the edge producing 0.
//   3. Down wrap, MAX_COUNT=9: load 1, down -> 0, 9, 8; tc=1 only on the edge producing 9.
//   4. Saturate, WIDTH=8, MAX_COUNT=200: load 250 -> count=200 (clamped).
//      Up 3 steps -> count stays 200, tc=1 on each step.
//   5. Prescale=4: enable=1 continuously from count=0.
//      -> count steps on edges 4, 8, 12. Drop enable for 2 cycles after edge 5 -> next step at edge 10.
//   6. Priority: clear=1, load=1 (load_value=7), step due on the same edge -> count=0, tc=0.
//      Next edge with load=1 only -> count=7.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the counter/timer family: direction encoding and
// end-of-range behaviour selectors.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

endpackage : counter_pkg

// File: rtl/count_prescaler.sv
// Enable prescaler: emits one tick for every PRESCALE cycles with enable=1.
// The phase counter holds while enable is low and restarts from 0 on clear.
// With PRESCALE=1 the phase never leaves 0, so tick follows enable directly.
module count_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase;
   logic          at_last;

   assign at_last = (phase == LAST);
   assign tick    = enable & at_last;

   // Phase counter: advances on enabled cycles, wraps after the tick cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         phase <= '0;
      end else if (clear) begin
         phase <= '0;
      end else if (enable) begin
         phase <= at_last ? '0 : phase + PW'(1);
      end
   end

endmodule : count_prescaler

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with clamped load, wrap or saturate at the
// range ends, an enable prescaler and a registered terminal-count pulse.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 15,
   parameter int SATURATE  = 0,
   parameter int PRESCALE  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             up_down,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_COUNT);
   localparam bit               WRAP_MODE = (SATURATE == MODE_WRAP);

   logic [WIDTH-1:0] count_next;
   logic             tc_next;
   logic             step;
   logic             going_up;
   logic             going_down;
   logic             at_top;
   logic             at_bottom;
   logic             at_end;
   logic             restart;

   // A load also restarts the prescaler so a fresh value gets a full period
   assign restart = clear | load;

   count_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clock  (clock),
      .reset  (reset),
      .clear  (restart),
      .enable (enable),
      .tick   (step)
   );

   assign going_up   = (up_down == DIR_UP);
   assign going_down = (up_down == DIR_DOWN);
   assign at_top     = (count == MAX_V);
   assign at_bottom  = (count == '0);
   // A step taken at the end in the current direction raises tc in both modes
   assign at_end     = (going_up & at_top) | (going_down & at_bottom);

   // Next-state mux: clear beats load beats step beats hold
   always_comb begin
      count_next = count;
      tc_next    = 1'b0;
      if (clear) begin
         count_next = '0;
      end else if (load) begin
         count_next = (load_value > MAX_V) ? MAX_V : load_value;
      end else if (step) begin
         tc_next = at_end;
         if (going_up) begin
            if (!at_top)        count_next = count + WIDTH'(1);
            else if (WRAP_MODE) count_next = '0;
            else                count_next = MAX_V;
         end else begin
            if (!at_bottom)     count_next = count - WIDTH'(1);
            else if (WRAP_MODE) count_next = MAX_V;
            else                count_next = '0;
         end
      end
   end

   // Count and terminal-count registers; reset clears both immediately
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= count_next;
         tc    <= tc_next;
      end
   end

endmodule : param_updown_counter

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: four instances cover the default
// wrap counter, a MAX_COUNT=9 down-wrap, an 8-bit saturating counter and a
// prescale-by-4 counter. Expected values are hand-computed constants.
module tb_param_updown_counter;

   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   // Instance A: defaults (WIDTH 4, MAX 15, wrap, prescale 1)
   logic       a_clear = 0, a_load = 0, a_enable = 0, a_up = 1;
   logic [3:0] a_load_value = '0;
   logic [3:0] a_count;
   logic       a_tc;

   // Instance B: MAX_COUNT 9, wrap
   logic       b_clear = 0, b_load = 0, b_enable = 0, b_up = 1;
   logic [3:0] b_load_value = '0;
   logic [3:0] b_count;
   logic       b_tc;

   // Instance C: WIDTH 8, MAX 200, saturate
   logic       c_clear = 0, c_load = 0, c_enable = 0, c_up = 1;
   logic [7:0] c_load_value = '0;
   logic [7:0] c_count;
   logic       c_tc;

   // Instance D: prescale 4
   logic       d_clear = 0, d_load = 0, d_enable = 0, d_up = 1;
   logic [3:0] d_load_value = '0;
   logic [3:0] d_count;
   logic       d_tc;

   param_updown_counter u_a (
      .clock(clock), .reset(reset), .clear(a_clear), .load(a_load),
      .load_value(a_load_value), .enable(a_enable), .up_down(a_up),
      .count(a_count), .tc(a_tc));

   param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .PRESCALE(1)) u_b (
      .clock(clock), .reset(reset), .clear(b_clear), .load(b_load),
      .load_value(b_load_value), .enable(b_enable), .up_down(b_up),
      .count(b_count), .tc(b_tc));

   param_updown_counter #(.WIDTH(8), .MAX_COUNT(200), .SATURATE(1), .PRESCALE(1)) u_c (
      .clock(clock), .reset(reset), .clear(c_clear), .load(c_load),
      .load_value(c_load_value), .enable(c_enable), .up_down(c_up),
      .count(c_count), .tc(c_tc));

   param_updown_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0), .PRESCALE(4)) u_d (
      .clock(clock), .reset(reset), .clear(d_clear), .load(d_load),
      .load_value(d_load_value), .enable(d_enable), .up_down(d_up),
      .count(d_count), .tc(d_tc));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it
   task automatic edge1();
      @(posedge clock);
      #1;
   endtask

   // Expected prescaled count after each enabled/disabled edge (index = edge-1)
   int pre_exp [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 2};

   initial begin
      // Reset state while held in reset
      edge1();
      edge1();
      check("rst_count", 32'(a_count), 32'd0);
      check("rst_tc",    32'(a_tc),    32'd0);
      #2 reset = 1'b1;
      edge1();

      // 1. Asynchronous reset mid-count at 9
      a_load = 1; a_load_value = 4'd8;
      edge1();
      check("t1_load8", 32'(a_count), 32'd8);
      a_load = 0; a_enable = 1; a_up = 1;
      edge1();
      check("t1_count9", 32'(a_count), 32'd9);
      #2 reset = 1'b0;
      #1;
      check("t1_async_count", 32'(a_count), 32'd0);
      check("t1_async_tc",    32'(a_tc),    32'd0);
      edge1();
      check("t1_held_count", 32'(a_count), 32'd0);
      reset = 1'b1;
      edge1();
      check("t1_step1", 32'(a_count), 32'd1);
      edge1();
      check("t1_step2", 32'(a_count), 32'd2);
      edge1();
      check("t1_step3", 32'(a_count), 32'd3);
      $display("test1 reset mid-count: count=%0d", a_count);

      // 2. Up wrap with defaults
      a_enable = 0; a_load = 1; a_load_value = 4'd14;
      edge1();
      check("t2_load14", 32'(a_count), 32'd14);
      a_load = 0; a_enable = 1; a_up = 1;
      edge1();
      check("t2_c15",  32'(a_count), 32'd15);
      check("t2_tc15", 32'(a_tc),    32'd0);
      edge1();
      check("t2_c0",   32'(a_count), 32'd0);
      check("t2_tc0",  32'(a_tc),    32'd1);
      edge1();
      check("t2_c1",   32'(a_count), 32'd1);
      check("t2_tc1",  32'(a_tc),    32'd0);
      $display("test2 up wrap: count=%0d", a_count);
      a_enable = 0;

      // 3. Down wrap, MAX_COUNT=9
      b_load = 1; b_load_value = 4'd1;
      edge1();
      check("t3_load1", 32'(b_count), 32'd1);
      b_load = 0; b_enable = 1; b_up = 0;
      edge1();
      check("t3_c0",  32'(b_count), 32'd0);
      check("t3_tc0", 32'(b_tc),    32'd0);
      edge1();
      check("t3_c9",  32'(b_count), 32'd9);
      check("t3_tc9", 32'(b_tc),    32'd1);
      edge1();
      check("t3_c8",  32'(b_count), 32'd8);
      check("t3_tc8", 32'(b_tc),    32'd0);
      $display("test3 down wrap: count=%0d", b_count);
      b_enable = 0;

      // 4. Saturate, WIDTH=8, MAX_COUNT=200, clamped load
      c_load = 1; c_load_value = 8'd250;
      edge1();
      check("t4_clamp",    32'(c_count), 32'd200);
      check("t4_clamp_tc", 32'(c_tc),    32'd0);
      c_load = 0; c_enable = 1; c_up = 1;
      for (int i = 0; i < 3; i++) begin
         edge1();
         check($sformatf("t4_hold%0d", i),    32'(c_count), 32'd200);
         check($sformatf("t4_hold_tc%0d", i), 32'(c_tc),    32'd1);
      end
      c_up = 0;
      edge1();
      check("t4_down199", 32'(c_count), 32'd199);
      check("t4_down_tc", 32'(c_tc),    32'd0);
      c_enable = 0; c_load = 1; c_load_value = 8'd0;
      edge1();
      c_load = 0; c_enable = 1;
      edge1();
      check("t4_floor",    32'(c_count), 32'd0);
      check("t4_floor_tc", 32'(c_tc),    32'd1);
      $display("test4 saturate: count=%0d", c_count);
      c_enable = 0;

      // 5. Prescale by 4, enable dropped for edges 6 and 7
      d_clear = 1;
      edge1();
      d_clear = 0; d_enable = 1; d_up = 1;
      for (int e = 1; e <= 10; e++) begin
         edge1();
         check($sformatf("t5_edge%0d", e), 32'(d_count), 32'(pre_exp[e-1]));
         check($sformatf("t5_tc%0d", e),   32'(d_tc),    32'd0);
         if (e == 5) d_enable = 0;
         if (e == 7) d_enable = 1;
      end
      $display("test5 prescale: count=%0d", d_count);
      d_enable = 0;

      // 6. Priority: clear beats load beats a due step at the range end
      a_load = 1; a_load_value = 4'd15;
      edge1();
      a_clear = 1; a_load = 1; a_load_value = 4'd7; a_enable = 1; a_up = 1;
      edge1();
      check("t6_clear_count", 32'(a_count), 32'd0);
      check("t6_clear_tc",    32'(a_tc),    32'd0);
      a_clear = 0;
      edge1();
      check("t6_load_count", 32'(a_count), 32'd7);
      check("t6_load_tc",    32'(a_tc),    32'd0);
      $display("test6 priority: count=%0d", a_count);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_param_updown_counter
